// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: default geometry, FSM state
// encoding and PC field extraction helpers.
package bpu_pkg;

    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned INDEX_W_DEF = 10;
    localparam int unsigned TAG_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF   = 2;

    // Width of one stored entry: valid + tag + target + counter.
    localparam int unsigned ENTRY_W_DEF = 1 + TAG_W_DEF + PC_W_DEF + CNT_W_DEF;

    typedef enum logic {
        StSweep = 1'b0,
        StRun   = 1'b1
    } bpu_state_e;

    // Entry index: pc[2 +: index_w].
    function automatic logic [63:0] pc_index(logic [63:0] pc, int unsigned index_w);
        return (pc >> 2) & ((64'd1 << index_w) - 64'd1);
    endfunction

    // Entry tag: pc[2+index_w +: tag_w].
    function automatic logic [63:0] pc_tag(logic [63:0] pc, int unsigned index_w,
                                           int unsigned tag_w);
        return (pc >> (2 + index_w)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bpu_btb_if.sv
// Lookup/update/status bundle between the pipeline and the branch target buffer.
interface bpu_btb_if #(
    parameter int unsigned PC_W = 32
);
    logic            flush;
    logic [PC_W-1:0] lk_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_next_pc;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            ready;

    modport master (
        output flush, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_next_pc, ready
    );

    modport slave (
        input  flush, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_next_pc, ready
    );
endinterface

// File: rtl/bpu_sat_counter.sv
// Combinational saturating up/down direction counter.
module bpu_sat_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_next
);

    // Step toward taken/not-taken, holding at the rails.
    always_comb begin
        cnt_next = cnt;
        if (taken && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!taken && (cnt != '0)) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Tagged branch target buffer with saturating direction counters, registered
// lookup and a clearing sweep after reset or flush.
// Optional macro BTB_FWD_EN: same-edge lookup/update to one index returns the
// post-update entry.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input logic      clk,
    input logic      rst,
    bpu_btb_if.slave bus
);

    localparam int unsigned N = 1 << INDEX_W;

    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [PC_W-1:0]  target_q [N];
    logic [CNT_W-1:0] cnt_q    [N];

    bpu_state_e       state_q, state_d;
    logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;

    logic               pred_hit_q, pred_taken_q;
    logic [PC_W-1:0]    pred_next_pc_q;

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    assign lk_idx = INDEX_W'(pc_index(64'(bus.lk_pc), INDEX_W));
    assign lk_tag = TAG_W'(pc_tag(64'(bus.lk_pc), INDEX_W, TAG_W));
    assign up_idx = INDEX_W'(pc_index(64'(bus.upd_pc), INDEX_W));
    assign up_tag = TAG_W'(pc_tag(64'(bus.upd_pc), INDEX_W, TAG_W));

    logic             up_hit, upd_ok, upd_we;
    logic [CNT_W-1:0] cnt_step;
    logic             new_valid;
    logic [TAG_W-1:0] new_tag;
    logic [PC_W-1:0]  new_target;
    logic [CNT_W-1:0] new_cnt;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign upd_ok = bus.upd_en && (state_q == StRun) && !bus.flush && !rst;

    bpu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt      (cnt_q[up_idx]),
        .taken    (bus.upd_taken),
        .cnt_next (cnt_step)
    );

    // Next value of the entry addressed by the update port.
    always_comb begin
        new_valid  = valid_q[up_idx];
        new_tag    = tag_q[up_idx];
        new_target = target_q[up_idx];
        new_cnt    = cnt_q[up_idx];
        upd_we     = 1'b0;
        if (upd_ok) begin
            if (up_hit) begin
                new_cnt = cnt_step;
                if (bus.upd_taken) begin
                    new_target = bus.upd_target;
                end
                upd_we = 1'b1;
            end else if (bus.upd_taken) begin
                new_valid          = 1'b1;
                new_tag            = up_tag;
                new_target         = bus.upd_target;
                new_cnt            = '0;
                new_cnt[CNT_W-1]   = 1'b1;
                upd_we             = 1'b1;
            end
        end
    end

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic [CNT_W-1:0] rd_cnt;
    logic             lk_hit, lk_taken;
    logic [PC_W-1:0]  lk_next;

    // Read the looked-up entry and form the prediction.
    always_comb begin
        rd_valid  = valid_q[lk_idx];
        rd_tag    = tag_q[lk_idx];
        rd_target = target_q[lk_idx];
        rd_cnt    = cnt_q[lk_idx];
`ifdef BTB_FWD_EN
        if (upd_we && (up_idx == lk_idx)) begin
            rd_valid  = new_valid;
            rd_tag    = new_tag;
            rd_target = new_target;
            rd_cnt    = new_cnt;
        end
`endif
        lk_hit   = rd_valid && (rd_tag == lk_tag);
        lk_taken = lk_hit && rd_cnt[CNT_W-1];
        lk_next  = lk_taken ? rd_target : bus.lk_pc + PC_W'(4);
    end

    // Sweep/run sequencing.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            StSweep: begin
                sweep_idx_d = sweep_idx_q + INDEX_W'(1);
                if (sweep_idx_q == {INDEX_W{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.flush) begin
                    state_d     = StSweep;
                    sweep_idx_d = '0;
                end
            end
            default: state_d = StSweep;
        endcase
    end

    // State register and registered prediction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StSweep;
            sweep_idx_q    <= '0;
            pred_hit_q     <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_next_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            if (state_q == StSweep) begin
                pred_hit_q     <= 1'b0;
                pred_taken_q   <= 1'b0;
                pred_next_pc_q <= bus.lk_pc + PC_W'(4);
            end else begin
                pred_hit_q     <= lk_hit;
                pred_taken_q   <= lk_taken;
                pred_next_pc_q <= lk_next;
            end
        end
    end

    // Entry array write: sweep clearing takes priority over updates.
    always_ff @(posedge clk) begin
        if (state_q == StSweep) begin
            valid_q[sweep_idx_q] <= 1'b0;
            cnt_q[sweep_idx_q]   <= '0;
        end else if (upd_we) begin
            valid_q[up_idx]  <= new_valid;
            tag_q[up_idx]    <= new_tag;
            target_q[up_idx] <= new_target;
            cnt_q[up_idx]    <= new_cnt;
        end
    end

    assign bus.pred_hit     = pred_hit_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.pred_next_pc = pred_next_pc_q;
    assign bus.ready        = (state_q == StRun);

endmodule

// File: tb/tb_bpu_btb.sv
// Randomized self-checking bench for bpu_btb against an entry-table reference model.
module tb_bpu_btb;

`ifdef BTB_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif
    localparam int NENT = 1024;

    logic clk;
    logic rst;

    bpu_btb_if #(.PC_W(32)) bus ();

    bpu_btb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the table as the specification describes it.
    bit          m_valid  [NENT];
    int unsigned m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_cnt    [NENT];
    int          sweep_left;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % NENT;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return (pc / 4096) % 256;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_apply(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        int unsigned i = idx_of(pc);
        int unsigned t = tag_of(pc);
        if (m_valid[i] && m_tag[i] == t) begin
            if (tk) begin
                m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_target[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = t;
            m_target[i] = tgt;
            m_cnt[i]    = 2;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                                output logic [31:0] nxt);
        int unsigned i = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_cnt[i] >= 2);
        nxt = tk ? m_target[i] : pc + 32'd4;
    endtask

    // One clock: predict from the model, take the edge, compare.
    task automatic step();
        bit          e_hit, e_tk;
        logic [31:0] e_nxt;
        if (rst) begin
            e_hit = 0; e_tk = 0; e_nxt = '0;
            sweep_left = NENT;
            model_clear();
        end else if (sweep_left > 0) begin
            e_hit = 0; e_tk = 0; e_nxt = bus.lk_pc + 32'd4;
            sweep_left--;
        end else begin
            if (Fwd && !bus.flush && bus.upd_en)
                model_apply(bus.upd_pc, bus.upd_taken, bus.upd_target);
            model_lookup(bus.lk_pc, e_hit, e_tk, e_nxt);
            if (bus.flush) begin
                sweep_left = NENT;
                model_clear();
            end else if (!Fwd && bus.upd_en) begin
                model_apply(bus.upd_pc, bus.upd_taken, bus.upd_target);
            end
        end
        @(posedge clk);
        #1;
        check("pred_hit", 64'(bus.pred_hit), 64'(e_hit));
        check("pred_taken", 64'(bus.pred_taken), 64'(e_tk));
        check("pred_next_pc", 64'(bus.pred_next_pc), 64'(e_nxt));
        check("ready", 64'(bus.ready), 64'(sweep_left == 0));
    endtask

    task automatic drive(input logic [31:0] lk, input bit en, input logic [31:0] upc,
                         input bit tk, input logic [31:0] tgt);
        bus.flush      = 1'b0;
        bus.lk_pc      = lk;
        bus.upd_en     = en;
        bus.upd_pc     = upc;
        bus.upd_taken  = tk;
        bus.upd_target = tgt;
    endtask

    // Run the sweep to completion with noise updates; returns ready-low sample count.
    task automatic run_sweep(input int already, output int low);
        low = already;
        for (int k = 0; k < 1100 && !bus.ready; k++) begin
            drive(32'h100, 1'($urandom_range(0, 1)), 32'h40, 1'b1, $urandom);
            step();
            if (!bus.ready) low++;
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        p[19:12] = 8'($urandom_range(0, 3));
        p[11:2]  = 10'($urandom_range(0, 7));
        return p;
    endfunction

    int low;

    initial begin
        sweep_left = NENT;
        rst = 1'b1;
        drive(32'h100, 1'b0, '0, 1'b0, '0);
        step();
        step();
        check("rst_next_pc", 64'(bus.pred_next_pc), 64'h0);
        rst = 1'b0;
        // Reset sweep: the sample after the reset edge already counts as low.
        run_sweep(1, low);
        check("sweep_len_rst", 64'(low), 64'd1024);

        drive(32'h100, 1'b0, '0, 1'b0, '0);
        step();
        check("miss_empty", 64'(bus.pred_hit), 64'd0);

        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h200);
        step();
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("alloc_hit", 64'(bus.pred_hit), 64'd1);
        check("alloc_taken", 64'(bus.pred_taken), 64'd1);
        check("alloc_target", 64'(bus.pred_next_pc), 64'h200);

        for (int k = 0; k < 2; k++) begin
            drive(32'h0, 1'b1, 32'h40, 1'b0, 32'h999);
            step();
        end
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("nt_hit", 64'(bus.pred_hit), 64'd1);
        check("nt_taken", 64'(bus.pred_taken), 64'd0);
        check("nt_next", 64'(bus.pred_next_pc), 64'h44);

        // Floor at 0, then four taken (saturate at 3), then 3->2 still taken, 2->1 not.
        drive(32'h0, 1'b1, 32'h40, 1'b0, '0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h240);
            step();
        end
        drive(32'h0, 1'b1, 32'h40, 1'b0, '0);
        step();
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("sat_taken", 64'(bus.pred_taken), 64'd1);
        check("sat_target", 64'(bus.pred_next_pc), 64'h240);
        drive(32'h0, 1'b1, 32'h40, 1'b0, '0);
        step();
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("sat_down", 64'(bus.pred_taken), 64'd0);

        drive(32'h1040, 1'b0, '0, 1'b0, '0);
        step();
        check("alias_miss", 64'(bus.pred_hit), 64'd0);
        drive(32'h0, 1'b1, 32'h1040, 1'b1, 32'h500);
        step();
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("alias_evict", 64'(bus.pred_hit), 64'd0);
        drive(32'h1040, 1'b0, '0, 1'b0, '0);
        step();
        check("alias_next", 64'(bus.pred_next_pc), 64'h500);

        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300);
        step();
        check("same_edge_hit", 64'(bus.pred_hit), 64'(Fwd));
        check("same_edge_next", 64'(bus.pred_next_pc), Fwd ? 64'h300 : 64'h84);

        for (int k = 0; k < 3000; k++) begin
            drive(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
                  ($urandom_range(0, 9) < 6), $urandom);
            bus.flush = ($urandom_range(0, 799) == 0);
            step();
        end
        run_sweep(0, low);

        // Flush in RUN with an allocated entry.
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h200);
        step();
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h200);
        bus.flush = 1'b1;
        step();
        check("flush_ready", 64'(bus.ready), 64'd0);
        run_sweep(1, low);
        check("sweep_len_flush", 64'(low), 64'd1024);
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("flush_cleared", 64'(bus.pred_hit), 64'd0);

        // Reset in the middle of a sweep restarts it from zero.
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h200);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 500; k++) begin
            drive(32'h100, 1'b1, 32'h40, 1'b1, 32'h200);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_sweep(1, low);
        check("sweep_len_rst2", 64'(low), 64'd1024);
        drive(32'h40, 1'b0, '0, 1'b0, '0);
        step();
        check("rst_cleared", 64'(bus.pred_hit), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
